execute_reg: RTL

- D->E pipeline register of the Y86-64 five-stage pipeline.
- Sits between decode, which produces d_* signals including the forwarded/merged valA, and execute, which consumes E_*.
- Each cycle it latches decode outputs, holds them under stall, or injects a NOP bubble under control from pipeline control logic.
- Constant encodings come from define.v.

---
 rtl/execute_reg.sv | 121 ++++++++++++
 1 files changed

// File: rtl/execute_reg.sv
// D->E pipeline register for the Y86-64 pipeline: it loads, holds (stall) or injects a NOP bubble.
// Optional macro E_PERF_CNT_EN adds saturating bubble and stall event counters.
module execute_reg #(
   parameter int DATA_W = 64,
   parameter int REG_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              E_stall_i,
   input  logic              E_bubble_i,
   input  logic [REG_W-1:0]  d_stat_i,
   input  logic [REG_W-1:0]  d_icode_i,
   input  logic [REG_W-1:0]  d_ifun_i,
   input  logic [DATA_W-1:0] d_valC_i,
   input  logic [DATA_W-1:0] d_valA_i,
   input  logic [DATA_W-1:0] d_valB_i,
   input  logic [REG_W-1:0]  d_dstE_i,
   input  logic [REG_W-1:0]  d_dstM_i,
   input  logic [REG_W-1:0]  d_srcA_i,
   input  logic [REG_W-1:0]  d_srcB_i,
   output logic [REG_W-1:0]  E_stat_o,
   output logic [REG_W-1:0]  E_icode_o,
   output logic [REG_W-1:0]  E_ifun_o,
   output logic [DATA_W-1:0] E_valC_o,
   output logic [DATA_W-1:0] E_valA_o,
   output logic [DATA_W-1:0] E_valB_o,
   output logic [REG_W-1:0]  E_dstE_o,
   output logic [REG_W-1:0]  E_dstM_o,
   output logic [REG_W-1:0]  E_srcA_o,
   output logic [REG_W-1:0]  E_srcB_o,
`ifdef E_PERF_CNT_EN
   output logic [31:0]       E_bubble_cnt_o,
   output logic [31:0]       E_stall_cnt_o,
`endif
   output logic              E_valid_o
);

   // Y86-64 encodings used by the bubble image (mirrors define.v)
   localparam logic [REG_W-1:0] SBUB  = REG_W'(4'h0);
   localparam logic [REG_W-1:0] INOP  = REG_W'(4'h1);
   localparam logic [REG_W-1:0] RNONE = REG_W'(4'hF);

   logic [REG_W-1:0]  r_stat_p1;
   logic [REG_W-1:0]  r_icode_p1;
   logic [REG_W-1:0]  r_ifun_p1;
   logic [DATA_W-1:0] r_valC_p1;
   logic [DATA_W-1:0] r_valA_p1;
   logic [DATA_W-1:0] r_valB_p1;
   logic [REG_W-1:0]  r_dstE_p1;
   logic [REG_W-1:0]  r_dstM_p1;
   logic [REG_W-1:0]  r_srcA_p1;
   logic [REG_W-1:0]  r_srcB_p1;
   logic              r_vld_p1;

   // Reset and bubble share one image; bubble overrides stall
   always_ff @(posedge clk_i) begin
      if (rst_i || E_bubble_i) begin
         r_stat_p1  <= SBUB;
         r_icode_p1 <= INOP;
         r_ifun_p1  <= '0;
         r_valC_p1  <= '0;
         r_valA_p1  <= '0;
         r_valB_p1  <= '0;
         r_dstE_p1  <= RNONE;
         r_dstM_p1  <= RNONE;
         r_srcA_p1  <= RNONE;
         r_srcB_p1  <= RNONE;
         r_vld_p1   <= 1'b0;
      end else if (!E_stall_i) begin
         r_stat_p1  <= d_stat_i;
         r_icode_p1 <= d_icode_i;
         r_ifun_p1  <= d_ifun_i;
         r_valC_p1  <= d_valC_i;
         r_valA_p1  <= d_valA_i;
         r_valB_p1  <= d_valB_i;
         r_dstE_p1  <= d_dstE_i;
         r_dstM_p1  <= d_dstM_i;
         r_srcA_p1  <= d_srcA_i;
         r_srcB_p1  <= d_srcB_i;
         r_vld_p1   <= 1'b1;
      end
   end

   assign E_stat_o  = r_stat_p1;
   assign E_icode_o = r_icode_p1;
   assign E_ifun_o  = r_ifun_p1;
   assign E_valC_o  = r_valC_p1;
   assign E_valA_o  = r_valA_p1;
   assign E_valB_o  = r_valB_p1;
   assign E_dstE_o  = r_dstE_p1;
   assign E_dstM_o  = r_dstM_p1;
   assign E_srcA_o  = r_srcA_p1;
   assign E_srcB_o  = r_srcB_p1;
   assign E_valid_o = r_vld_p1;

`ifdef E_PERF_CNT_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   logic [31:0] r_bubble_cnt;
   logic [31:0] r_stall_cnt;

   // A bubble+stall edge counts only as a bubble, matching what the register did
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_bubble_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (E_bubble_i)
            r_bubble_cnt <= sat_inc(r_bubble_cnt);
         if (E_stall_i && !E_bubble_i)
            r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

   assign E_bubble_cnt_o = r_bubble_cnt;
   assign E_stall_cnt_o  = r_stall_cnt;
`endif

endmodule
